// File: rtl/ccff_chain_bank.sv
// ccff_chain_bank
// NUM_CHAINS parallel configuration chains of CHAIN_LEN flops each, loaded
// serially on prog_clk with valid/ready flow control. A readback operation
// rotates every chain through its MSB, so the image is presented on
// ccff_tail in programming order and is intact after CHAIN_LEN beats.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset; waiting for start
// ST_SHIFT | operation in progress; one beat per accepted handshake
// ST_DONE  | CHAIN_LEN beats completed; bit_cnt holds, waits for start
module ccff_chain_bank #(
   parameter  int NUM_CHAINS = 4,
   parameter  int CHAIN_LEN  = 32,
   localparam int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
   input  logic                            prog_clk,
   input  logic                            pReset,
   input  logic                            start,
   input  logic                            mode,
   input  logic [NUM_CHAINS-1:0]           ccff_head,
   input  logic                            ccff_head_valid,
   output logic                            ccff_head_ready,
   output logic [NUM_CHAINS-1:0]           ccff_tail,
   output logic                            ccff_tail_valid,
   input  logic                            ccff_tail_ready,
   output logic [NUM_CHAINS*CHAIN_LEN-1:0] cfg_out,
   output logic                            cfg_valid,
   output logic                            busy,
   output logic                            done,
   output logic [CNT_W-1:0]                bit_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CHAIN_LEN - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_mode_q;
   logic             w_mode_nxt;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [CNT_W-1:0] w_bit_cnt_nxt;
   logic             r_cfg_valid;
   logic             w_cfg_valid_nxt;
   logic             w_prog_beat;
   logic             w_rdbk_beat;
   logic             w_beat;
   logic             w_last;

   assign ccff_head_ready = (r_state == ST_SHIFT) && !r_mode_q;
   assign ccff_tail_valid = (r_state == ST_SHIFT) &&  r_mode_q;

   assign w_prog_beat = ccff_head_valid && ccff_head_ready;
   assign w_rdbk_beat = ccff_tail_valid && ccff_tail_ready;
   assign w_beat      = w_prog_beat || w_rdbk_beat;
   // the beat that completes the chain length ends the operation
   assign w_last      = w_beat && (r_bit_cnt == LP_LAST);

   // control registers: state, latched mode, beat counter, image-valid flag
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         r_state     <= ST_IDLE;
         r_mode_q    <= 1'b0;
         r_bit_cnt   <= '0;
         r_cfg_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mode_q    <= w_mode_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_cfg_valid <= w_cfg_valid_nxt;
      end
   end

   // next-state logic; start only matters outside SHIFT
   always_comb begin
      w_state_nxt     = r_state;
      w_mode_nxt      = r_mode_q;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_cfg_valid_nxt = r_cfg_valid;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nxt   = ST_SHIFT;
               w_mode_nxt    = mode;
               w_bit_cnt_nxt = '0;
               // a new program invalidates the old image right away
               if (!mode) begin
                  w_cfg_valid_nxt = 1'b0;
               end
            end
         end
         ST_SHIFT: begin
            if (w_beat) begin
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               if (w_last) begin
                  w_state_nxt = ST_DONE;
                  if (!r_mode_q) begin
                     w_cfg_valid_nxt = 1'b1;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // per-chain storage; program shifts in ccff_head, readback rotates the MSB
   for (genvar gc = 0; gc < NUM_CHAINS; gc++) begin : g_chain
      logic [CHAIN_LEN-1:0] r_chain;
      logic                 w_in_bit;
      logic [CHAIN_LEN-1:0] w_shifted;

      assign w_in_bit = r_mode_q ? r_chain[CHAIN_LEN-1] : ccff_head[gc];

      if (CHAIN_LEN == 1) begin : g_len1
         assign w_shifted = w_in_bit;
      end else begin : g_lenn
         assign w_shifted = {r_chain[CHAIN_LEN-2:0], w_in_bit};
      end

      // advance the chain by one position on each accepted beat
      always_ff @(posedge prog_clk or posedge pReset) begin
         if (pReset) begin
            r_chain <= '0;
         end else if (w_beat) begin
            r_chain <= w_shifted;
         end
      end

      assign cfg_out[gc*CHAIN_LEN +: CHAIN_LEN] = r_chain;
      assign ccff_tail[gc]                      = r_chain[CHAIN_LEN-1];
   end

   assign cfg_valid = r_cfg_valid;
   assign busy      = (r_state == ST_SHIFT);
   assign done      = (r_state == ST_DONE);
   assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_ccff_chain_bank.sv
// Bench for ccff_chain_bank: a 4x8 instance checked every cycle against an
// arithmetic model of the chain images, plus a 2x1 instance with directed checks.
module tb_ccff_chain_bank;
   localparam int N  = 4;
   localparam int L  = 8;
   localparam int CW = $clog2(L + 1);
   localparam int OW = 4 + CW + 1 + N + N * L;

   logic           prog_clk = 1'b0;
   logic           pReset;
   logic           start;
   logic           mode;
   logic [N-1:0]   ccff_head;
   logic           ccff_head_valid;
   logic           ccff_head_ready;
   logic [N-1:0]   ccff_tail;
   logic           ccff_tail_valid;
   logic           ccff_tail_ready;
   logic [N*L-1:0] cfg_out;
   logic           cfg_valid;
   logic           busy;
   logic           done;
   logic [CW-1:0]  bit_cnt;

   logic           b_rst;
   logic           b_start;
   logic           b_mode;
   logic [1:0]     b_head;
   logic           b_head_valid;
   logic           b_head_ready;
   logic [1:0]     b_tail;
   logic           b_tail_valid;
   logic           b_tail_ready;
   logic [1:0]     b_cfg_out;
   logic           b_cfg_valid;
   logic           b_busy;
   logic           b_done;
   logic [0:0]     b_bit_cnt;

   int nvec = 0;
   int nerr = 0;

   ccff_chain_bank #(.NUM_CHAINS(N), .CHAIN_LEN(L)) dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start), .mode(mode),
      .ccff_head(ccff_head), .ccff_head_valid(ccff_head_valid),
      .ccff_head_ready(ccff_head_ready), .ccff_tail(ccff_tail),
      .ccff_tail_valid(ccff_tail_valid), .ccff_tail_ready(ccff_tail_ready),
      .cfg_out(cfg_out), .cfg_valid(cfg_valid), .busy(busy), .done(done),
      .bit_cnt(bit_cnt)
   );

   ccff_chain_bank #(.NUM_CHAINS(2), .CHAIN_LEN(1)) dut_len1 (
      .prog_clk(prog_clk), .pReset(b_rst), .start(b_start), .mode(b_mode),
      .ccff_head(b_head), .ccff_head_valid(b_head_valid),
      .ccff_head_ready(b_head_ready), .ccff_tail(b_tail),
      .ccff_tail_valid(b_tail_valid), .ccff_tail_ready(b_tail_ready),
      .cfg_out(b_cfg_out), .cfg_valid(b_cfg_valid), .busy(b_busy), .done(b_done),
      .bit_cnt(b_bit_cnt)
   );

   always #5 prog_clk = ~prog_clk;

   logic [OW-1:0] dut_obs;
   assign dut_obs = {busy, done, ccff_head_ready, ccff_tail_valid, bit_cnt,
                     cfg_valid, ccff_tail, cfg_out};

   // reference model: 0 idle, 1 shifting, 2 done; images kept as integers
   int m_state;
   bit m_mode;
   int m_cnt;
   bit m_cfgv;
   int m_img [N];

   logic [L-1:0] pat [N];
   bit           q_bits [N][$];

   task automatic model_reset();
      m_state = 0;
      m_mode  = 1'b0;
      m_cnt   = 0;
      m_cfgv  = 1'b0;
      for (int c = 0; c < N; c++) m_img[c] = 0;
   endtask

   task automatic model_edge();
      int  msb;
      int  inb;
      bit  beat;
      if (m_state != 1) begin
         if (start) begin
            m_state = 1;
            m_mode  = mode;
            m_cnt   = 0;
            if (!mode) m_cfgv = 1'b0;
         end
      end else begin
         beat = m_mode ? ccff_tail_ready : ccff_head_valid;
         if (beat) begin
            for (int c = 0; c < N; c++) begin
               msb      = (m_img[c] >> (L - 1)) & 1;
               inb      = m_mode ? msb : int'(ccff_head[c]);
               m_img[c] = ((m_img[c] * 2) + inb) % (1 << L);
            end
            m_cnt++;
            if (m_cnt == L) begin
               m_state = 2;
               if (!m_mode) m_cfgv = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [OW-1:0] model_obs();
      logic [N*L-1:0] img;
      logic [N-1:0]   tl;
      for (int c = 0; c < N; c++) begin
         img[c*L +: L] = L'(m_img[c]);
         tl[c]         = m_img[c][L-1];
      end
      return {(m_state == 1), (m_state == 2), (m_state == 1 && !m_mode),
              (m_state == 1 && m_mode), CW'(m_cnt), m_cfgv, tl, img};
   endfunction

   task automatic tick();
      if (pReset) model_reset();
      else        model_edge();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic test_reset();
      pReset = 1'b1;
      model_reset();
      #3;
      nvec++;
      if (dut_obs !== model_obs()) begin
         nerr++;
         $display("FAIL reset_async: got %h want %h", dut_obs, model_obs());
      end
      tick();
      nvec++;
      if (dut_obs !== model_obs()) begin
         nerr++;
         $display("FAIL reset_held: got %h want %h", dut_obs, model_obs());
      end
      pReset = 1'b0;
      tick();
   endtask

   task automatic test_program();
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 0; k < L; k++) begin
         for (int c = 0; c < N; c++) ccff_head[c] = pat[c][L-1-k];
         ccff_head_valid = 1'b1;
         nvec++;
         if (dut_obs !== model_obs()) begin
            nerr++;
            $display("FAIL program_beat%0d: got %h want %h", k, dut_obs, model_obs());
         end
         tick();
      end
      ccff_head_valid = 1'b0;
      nvec++;
      if ({done, cfg_valid, bit_cnt, cfg_out} !== {1'b1, 1'b1, CW'(8), 32'h01FF3CA5}) begin
         nerr++;
         $display("FAIL program_image: got done=%b cfgv=%b cnt=%0d cfg=%h want 1 1 8 01ff3ca5",
                  done, cfg_valid, bit_cnt, cfg_out);
      end
   endtask

   task automatic test_readback();
      logic [N-1:0] exp_tail;
      start = 1'b1; mode = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < L; k++) begin
         for (int c = 0; c < N; c++) exp_tail[c] = pat[c][L-1-k];
         nvec++;
         if (ccff_tail !== exp_tail) begin
            nerr++;
            $display("FAIL readback_tail%0d: got %b want %b", k, ccff_tail, exp_tail);
         end
         ccff_tail_ready = 1'b1;
         tick();
      end
      ccff_tail_ready = 1'b0;
      nvec++;
      if ({done, cfg_valid, cfg_out} !== {1'b1, 1'b1, 32'h01FF3CA5}) begin
         nerr++;
         $display("FAIL readback_restore: got done=%b cfgv=%b cfg=%h want 1 1 01ff3ca5",
                  done, cfg_valid, cfg_out);
      end
      nvec++;
      if (dut_obs !== model_obs()) begin
         nerr++;
         $display("FAIL readback_model: got %h want %h", dut_obs, model_obs());
      end
   endtask

   task automatic test_valid_toggle();
      for (int c = 0; c < N; c++) q_bits[c].delete();
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 24; i++) begin
         ccff_head       = N'($urandom);
         ccff_head_valid = (i % 3 == 0);
         if (m_state == 1 && !m_mode && ccff_head_valid)
            for (int c = 0; c < N; c++) q_bits[c].push_back(ccff_head[c]);
         tick();
         nvec++;
         if (dut_obs !== model_obs()) begin
            nerr++;
            $display("FAIL valid_toggle_cyc%0d: got %h want %h", i, dut_obs, model_obs());
         end
      end
      ccff_head_valid = 1'b0;
      nvec++;
      if ({done, bit_cnt} !== {1'b1, CW'(L)}) begin
         nerr++;
         $display("FAIL valid_toggle_done: got done=%b cnt=%0d want 1 %0d", done, bit_cnt, L);
      end
   endtask

   task automatic test_readback_stall();
      logic [N-1:0] exp_tail;
      start = 1'b1; mode = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 13; i++) begin
         ccff_tail_ready = (i < 3 || i >= 8);
         if (ccff_tail_ready) begin
            for (int c = 0; c < N; c++) exp_tail[c] = q_bits[c].pop_front();
            nvec++;
            if (ccff_tail !== exp_tail) begin
               nerr++;
               $display("FAIL stall_tail%0d: got %b want %b", i, ccff_tail, exp_tail);
            end
         end
         tick();
         nvec++;
         if (dut_obs !== model_obs()) begin
            nerr++;
            $display("FAIL stall_cyc%0d: got %h want %h", i, dut_obs, model_obs());
         end
      end
      ccff_tail_ready = 1'b0;
   endtask

   task automatic test_start_ignored();
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      ccff_head_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ccff_head = N'($urandom);
         tick();
      end
      start = 1'b1; mode = 1'b1; ccff_head = N'($urandom);
      tick();
      nvec++;
      if ({ccff_head_ready, bit_cnt} !== {1'b1, CW'(4)} || dut_obs !== model_obs()) begin
         nerr++;
         $display("FAIL start_in_shift: got %h want %h", dut_obs, model_obs());
      end
      start = 1'b0; mode = 1'b0; ccff_head = N'($urandom);
      tick();
      ccff_head_valid = 1'b0;
      nvec++;
      if (dut_obs !== model_obs()) begin
         nerr++;
         $display("FAIL shift_cnt5: got %h want %h", dut_obs, model_obs());
      end
      #2;
      pReset = 1'b1;
      #1;
      model_reset();
      nvec++;
      if ({busy, done, bit_cnt, cfg_valid, cfg_out} !== '0) begin
         nerr++;
         $display("FAIL mid_reset: got busy=%b done=%b cnt=%0d cfgv=%b cfg=%h want all 0",
                  busy, done, bit_cnt, cfg_valid, cfg_out);
      end
      start = 1'b1;
      tick();
      nvec++;
      if (dut_obs !== model_obs()) begin
         nerr++;
         $display("FAIL reset_beats_start: got %h want %h", dut_obs, model_obs());
      end
      start  = 1'b0;
      pReset = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 6; r++) begin
         start = 1'b1; mode = 1'(r % 2 == 1 ? $urandom : 0);
         tick();
         for (int i = 0; i < 40; i++) begin
            start           = ($urandom_range(0, 7) == 0);
            mode            = 1'($urandom);
            ccff_head       = N'($urandom);
            ccff_head_valid = ($urandom_range(0, 9) < 7);
            ccff_tail_ready = ($urandom_range(0, 9) < 7);
            tick();
            nvec++;
            if (dut_obs !== model_obs()) begin
               nerr++;
               $display("FAIL random_r%0d_c%0d: got %h want %h", r, i, dut_obs, model_obs());
            end
         end
      end
      start = 1'b0; ccff_head_valid = 1'b0; ccff_tail_ready = 1'b0;
   endtask

   task automatic test_len1();
      b_rst = 1'b0;
      b_start = 1'b1; b_mode = 1'b0;
      tick();
      b_start = 1'b0;
      nvec++;
      if ({b_busy, b_head_ready, b_cfg_valid} !== 3'b110) begin
         nerr++;
         $display("FAIL len1_start: got busy=%b rdy=%b cfgv=%b want 1 1 0",
                  b_busy, b_head_ready, b_cfg_valid);
      end
      b_head = 2'b10; b_head_valid = 1'b1;
      tick();
      b_head_valid = 1'b0; b_head = 2'b01;
      nvec++;
      if ({b_done, b_cfg_valid, b_bit_cnt, b_cfg_out, b_tail} !== 7'b1111010) begin
         nerr++;
         $display("FAIL len1_program: got done=%b cfgv=%b cnt=%b cfg=%b tail=%b want 1 1 1 10 10",
                  b_done, b_cfg_valid, b_bit_cnt, b_cfg_out, b_tail);
      end
      b_start = 1'b1; b_mode = 1'b1;
      tick();
      b_start = 1'b0;
      nvec++;
      if ({b_tail_valid, b_tail} !== 3'b110) begin
         nerr++;
         $display("FAIL len1_rb_tail: got valid=%b tail=%b want 1 10", b_tail_valid, b_tail);
      end
      b_tail_ready = 1'b1;
      tick();
      b_tail_ready = 1'b0;
      nvec++;
      if ({b_done, b_cfg_valid, b_cfg_out} !== 4'b1110) begin
         nerr++;
         $display("FAIL len1_rb_done: got done=%b cfgv=%b cfg=%b want 1 1 10",
                  b_done, b_cfg_valid, b_cfg_out);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      start = 1'b0; mode = 1'b0; ccff_head = '0;
      ccff_head_valid = 1'b0; ccff_tail_ready = 1'b0;
      b_rst = 1'b1; b_start = 1'b0; b_mode = 1'b0; b_head = '0;
      b_head_valid = 1'b0; b_tail_ready = 1'b0;
      pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF; pat[3] = 8'h01;
      test_reset();
      test_program();
      test_readback();
      test_valid_toggle();
      test_readback_stall();
      test_start_ignored();
      test_back_to_back();
      test_len1();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
